// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg: shared pipeline constants, stage indices and stage action decode
package pipe_stage_skid_pkg;
    localparam logic        STOP       = 1'b1;
    localparam logic        NOSTOP     = 1'b0;
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam int          DATA_W_DEF = 32;
    localparam int          ADDR_W_DEF = 32;
    localparam int          IF_ID      = 1;
    localparam int          ID_EX      = 2;
    localparam int          EX_MEM     = 3;
    localparam int          MEM_WB     = 4;

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_ADVANCE
    } stage_act_e;

    function automatic stage_act_e stage_act(input logic fl, input logic up, input logic dn);
        return fl ? ACT_FLUSH : (up & dn) ? ACT_HOLD : up ? ACT_BUBBLE : ACT_ADVANCE;
    endfunction
endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// sat_counter: counter that increments on inc and sticks at its all-ones value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    // count up, holding at the maximum instead of wrapping
    always_ff @(posedge clk_in) begin
        if (reset_in)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage register with one-entry skid buffer, flush and bubble counter
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                 DATA_W    = DATA_W_DEF,
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 STALL_W   = 6,
    parameter int                 STAGE_IDX = IF_ID,
    parameter int                 FLUSH_N   = 2,
    parameter int                 CNT_W     = 16,
    parameter logic [DATA_W-1:0]  NOP_INST  = DATA_W'(NOP)
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [DATA_W-1:0]   inst_in,
    input  logic [ADDR_W-1:0]   address_in,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [STALL_W-1:0]  stall_in,
    input  logic [FLUSH_N-1:0]  flush_in,
    output logic [DATA_W-1:0]   inst_out,
    output logic [ADDR_W-1:0]   address_out,
    output logic                valid_out,
    output logic                skid_full_out,
    output logic [CNT_W-1:0]    bubble_cnt_out
);
    logic              up, dn, fl, xfer, load_bubble;
    logic [DATA_W-1:0] skid_inst;
    logic [ADDR_W-1:0] skid_addr;
    stage_act_e        act;

    assign up          = stall_in[STAGE_IDX] == STOP;
    assign dn          = stall_in[STAGE_IDX+1] == STOP;
    assign fl          = |flush_in;
    assign act         = stage_act(fl, up, dn);
    assign ready_out   = fl | (!skid_full_out & !(up & !dn));
    assign xfer        = valid_in & ready_out;
    assign load_bubble = act == ACT_FLUSH || act == ACT_BUBBLE ||
                         (act == ACT_ADVANCE && !skid_full_out && !xfer);

    // output register: bubble, hold, or load from skid (preferred) or upstream
    always_ff @(posedge clk_in) begin
        if (reset_in || load_bubble) begin
            inst_out    <= NOP_INST;
            address_out <= '0;
            valid_out   <= 1'b0;
        end else if (act == ACT_ADVANCE) begin
            inst_out    <= skid_full_out ? skid_inst : inst_in;
            address_out <= skid_full_out ? skid_addr : address_in;
            valid_out   <= 1'b1;
        end
    end

    // skid occupancy: filled by a transfer during hold, drained by advance or flush
    always_ff @(posedge clk_in) begin
        if (reset_in)
            skid_full_out <= 1'b0;
        else if (act == ACT_HOLD)
            skid_full_out <= skid_full_out | xfer;
        else if (act != ACT_BUBBLE)
            skid_full_out <= 1'b0;
    end

    // skid payload: only meaningful while skid_full_out is set, so no reset needed
    always_ff @(posedge clk_in) begin
        if (act == ACT_HOLD && xfer) begin
            skid_inst <= inst_in;
            skid_addr <= address_in;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .inc      (load_bubble),
        .count    (bubble_cnt_out)
    );
endmodule
